// File: rtl/win_tone_gen.sv
// win_tone_gen: two-note square-wave jingle announcing a round result.
// Optional macro WIN_TONE_RETRIGGER_EN lets a new result restart a jingle.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   winrnd  in   one-cycle pulse: round decided
//   right   in   1 = right player won (qualifies winrnd)
//   tie     in   1 = tie, overrides right (qualifies winrnd)
//   speaker out  square-wave audio (registered)
//   gain    out  constant GAIN_SEL
//   en      out  amplifier enable, high while playing (registered)
//   busy    out  jingle in progress (registered)
module win_tone_gen #(
  parameter int LO_DIV   = 50000,
  parameter int HI_DIV   = 25000,
  parameter int TIE_DIV  = 100000,
  parameter int NOTE_LEN = 20000000,
  parameter bit GAIN_SEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic winrnd,
  input  logic right,
  input  logic tie,
  output logic speaker,
  output logic gain,
  output logic en,
  output logic busy
);

  localparam int MAX_LH  = (LO_DIV > HI_DIV) ? LO_DIV : HI_DIV;
  localparam int MAX_DIV = (MAX_LH > TIE_DIV) ? MAX_LH : TIE_DIV;
  localparam int DW = $clog2(MAX_DIV);
  localparam int NW = (NOTE_LEN > 1) ? $clog2(NOTE_LEN) : 1;

  localparam logic [DW-1:0] LO_M1  = DW'(LO_DIV - 1);
  localparam logic [DW-1:0] HI_M1  = DW'(HI_DIV - 1);
  localparam logic [DW-1:0] TIE_M1 = DW'(TIE_DIV - 1);
  localparam logic [NW-1:0] LEN_M1 = NW'(NOTE_LEN - 1);

  typedef enum logic [1:0] {IDLE, NOTE1, NOTE2} state_t;
  typedef enum logic [1:0] {EV_LEFT, EV_RIGHT, EV_TIE} ev_t;

  state_t        state, state_n;
  ev_t           ev, ev_n;
  logic [DW-1:0] div_cnt, div_n, div_top;
  logic [NW-1:0] note_cnt, note_n;
  logic          spk_n, en_n, busy_n;
  logic          trig;

  assign gain = GAIN_SEL;

`ifdef WIN_TONE_RETRIGGER_EN
  assign trig = winrnd;
`else
  assign trig = winrnd && (state == IDLE);
`endif

  // Half-period of the note currently playing.
  always_comb begin
    div_top = TIE_M1;
    unique case (1'b1)
      ev == EV_TIE:   div_top = TIE_M1;
      ev == EV_RIGHT: div_top = (state == NOTE2) ? HI_M1 : LO_M1;
      default:        div_top = (state == NOTE2) ? LO_M1 : HI_M1;
    endcase
  end

  always_comb begin
    state_n = state;
    ev_n    = ev;
    div_n   = div_cnt;
    note_n  = note_cnt;
    spk_n   = speaker;
    en_n    = en;
    busy_n  = busy;
    unique case (state)
      IDLE: ;
      NOTE1, NOTE2: begin
        if (div_cnt == div_top) begin
          div_n = '0;
          spk_n = ~speaker;
        end else begin
          div_n = div_cnt + 1'b1;
        end
        if (note_cnt == LEN_M1) begin
          // note boundary: next note (or silence) starts from a clean phase
          note_n = '0;
          div_n  = '0;
          spk_n  = 1'b0;
          if (state == NOTE1) begin
            state_n = NOTE2;
          end else begin
            state_n = IDLE;
            en_n    = 1'b0;
            busy_n  = 1'b0;
          end
        end else begin
          note_n = note_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (trig) begin
      ev_n    = tie ? EV_TIE : (right ? EV_RIGHT : EV_LEFT);
      state_n = NOTE1;
      div_n   = '0;
      note_n  = '0;
      spk_n   = 1'b0;
      en_n    = 1'b1;
      busy_n  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ev       <= EV_LEFT;
      div_cnt  <= '0;
      note_cnt <= '0;
      speaker  <= 1'b0;
      en       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ev       <= ev_n;
      div_cnt  <= div_n;
      note_cnt <= note_n;
      speaker  <= spk_n;
      en       <= en_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_win_tone_gen.sv
// tb_win_tone_gen: directed + random stimulus for win_tone_gen,
// checked cycle by cycle against an arithmetic jingle model.
module tb_win_tone_gen;

  localparam int LO  = 4;
  localparam int HI  = 2;
  localparam int TD  = 8;
  localparam int NL  = 16;
`ifdef WIN_TONE_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, winrnd, right, tie;
  logic speaker, gain, en, busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit started = 1'b0;
  int start = 0;
  int kind = 0;

  always #5 clk = ~clk;

  win_tone_gen #(
    .LO_DIV(LO), .HI_DIV(HI), .TIE_DIV(TD),
    .NOTE_LEN(NL), .GAIN_SEL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .winrnd(winrnd),
    .right(right), .tie(tie), .speaker(speaker),
    .gain(gain), .en(en), .busy(busy)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, obs, exp);
    end
  endtask

  // kind: 0 left, 1 right, 2 tie
  function automatic int div1(input int k);
    return (k == 2) ? TD : ((k == 1) ? LO : HI);
  endfunction

  function automatic int div2(input int k);
    return (k == 2) ? TD : ((k == 1) ? HI : LO);
  endfunction

  function automatic bit m_busy(input int c);
    return started && (c >= start) && (c < start + 2 * NL);
  endfunction

  task automatic step(input logic w, input logic r,
                      input logic t, input logic rs);
    int off;
    logic e_spk, e_act;
    rst = rs; winrnd = w; right = r; tie = t;
    @(posedge clk);
    if (rs) started = 1'b0;
    else if (w && (!m_busy(cyc) || RETRIG)) begin
      started = 1'b1;
      start = cyc + 1;
      kind = t ? 2 : (r ? 1 : 0);
    end
    cyc++;
    #1;
    e_act = m_busy(cyc);
    off = cyc - start;
    e_spk = 1'b0;
    if (e_act) begin
      if (off < NL) e_spk = ((off / div1(kind)) % 2) == 1;
      else e_spk = (((off - NL) / div2(kind)) % 2) == 1;
    end
    check("speaker", speaker, e_spk);
    check("en", en, e_act);
    check("busy", busy, e_act);
    check("gain", gain, 1'b1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'($urandom), 1'b0);
  endtask

  initial begin
    rst = 1'b1; winrnd = 1'b0; right = 1'b0; tie = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);
    // rising, falling, tie
    step(1'b1, 1'b1, 1'b0, 1'b0); idle(40);
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(40);
    step(1'b1, 1'b1, 1'b1, 1'b0); idle(40);
    // second result mid-jingle
    step(1'b1, 1'b1, 1'b0, 1'b0); idle(9);
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(45);
    // reset during NOTE2, then a fresh jingle
    step(1'b1, 1'b1, 1'b0, 1'b0); idle(19);
    step(1'b0, 1'b0, 1'b0, 1'b1); idle(4);
    step(1'b1, 1'b1, 1'b0, 1'b0); idle(40);
    // long pulse
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(40);
    // new result right on the first idle cycle
    step(1'b1, 1'b0, 1'b1, 1'b0); idle(32);
    step(1'b1, 1'b1, 1'b0, 1'b0); idle(40);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom % 25) == 0, 1'($urandom), 1'($urandom),
           ($urandom % 300) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/win_tone_gen.md
Name: win_tone_gen

Overview:
Sound stage downstream of the round-decision logic. Consumes the one-cycle round-result pulse and its qualifiers, and plays a short two-note square-wave jingle on the mono amplifier. The jingle rises for a right-player win, falls for a left-player win, and is a flat low buzz for a tie. Drives the top-level speaker, gain and en pins directly.

Parameters:
LO_DIV, 50000, half-period of the low note in clk cycles (must be >= 2)
HI_DIV, 25000, half-period of the high note in clk cycles (must be >= 2)
TIE_DIV, 100000, half-period of the tie buzz in clk cycles (must be >= 2)
NOTE_LEN, 20000000, duration of each note in clk cycles (must be >= 1)
GAIN_SEL, 1, constant value driven on gain (1 = 6 dB, 0 = 12 dB)

Ports:
clk  input  1  system clock, the single clock of the block
rst  input  1  reset, synchronous, active-high
winrnd  input  1  one-cycle pulse: a round has been decided
right  input  1  qualifier for winrnd: 1 = right player won, 0 = left player won
tie  input  1  qualifier for winrnd: 1 = tie (overrides right)
speaker  output  1  square-wave audio output
gain  output  1  amplifier gain select, constant GAIN_SEL
en  output  1  amplifier enable (active-high shutdown_n), high only while playing
busy  output  1  high while a jingle is playing

Behaviour:
- All outputs are registered except gain, which is a constant tie-off to GAIN_SEL.
- Reset (rst=1 at a clk edge): state=IDLE, speaker=0, en=0, busy=0, all counters=0. Reset applies on the next edge, including in the middle of a note.
- States: IDLE, NOTE1, NOTE2.
- IDLE: if winrnd=1 at edge k, latch the event type at that edge:
  - tie=1 -> TIE
  - else right=1 -> RIGHT
  - else -> LEFT
- At k+1: state=NOTE1, busy=1, en=1, speaker=0, divider and note counters at 0.
- Note divisors:
  - RIGHT: NOTE1=LO_DIV, NOTE2=HI_DIV (rising).
  - LEFT: NOTE1=HI_DIV, NOTE2=LO_DIV (falling).
  - TIE: NOTE1=NOTE2=TIE_DIV.
- Divider: div_cnt increments each cycle while in a note. When div_cnt==DIV-1, speaker toggles and div_cnt returns to 0. The first toggle occurs DIV cycles after note entry.
- Note counter: each note lasts exactly NOTE_LEN cycles.
  - NOTE1 covers cycles k+1..k+NOTE_LEN.
  - NOTE2 covers k+NOTE_LEN+1..k+2*NOTE_LEN. On entry to NOTE2, speaker is forced to 0 and div_cnt to 0.
- After NOTE2 completes, state=IDLE at k+2*NOTE_LEN+1 with speaker=0, en=0, busy=0.
- winrnd while busy: ignored (default build). The latched event type is unchanged.
- winrnd pulse longer than one cycle: only the first edge in IDLE triggers. Later edges fall under the busy rule.
- right and tie are don't-care when winrnd=0.
- Counter widths: $clog2 of the largest divisor and of NOTE_LEN respectively. No wrap-around is possible under the legal parameter ranges.
- A winrnd that arrives at the same edge the block returns to IDLE (k+2*NOTE_LEN+1) is accepted.

Optional Feature:
Macro WIN_TONE_RETRIGGER_EN.
- Defined: winrnd=1 while busy aborts the current jingle. At the same edge it latches the new event type, and on the next edge the block restarts NOTE1 with speaker=0 and counters=0. busy and en stay high continuously across the restart.
- Not defined: winrnd while busy is ignored, as described in Behaviour.

Test Plan:
Bench parameters: LO_DIV=4, HI_DIV=2, TIE_DIV=8, NOTE_LEN=16, GAIN_SEL=1.
1. Reset held 3 cycles then released, no winrnd -> speaker=0, en=0, busy=0, gain=1 throughout.
2. winrnd=1, right=1, tie=0 at edge k -> busy/en high k+1..k+32; speaker period 8 (toggles every 4 cycles) for 16 cycles, then period 4 for 16 cycles; back to IDLE with speaker=0 at k+33.
3. winrnd=1, right=0, tie=0 -> period 4 for 16 cycles then period 8 for 16 cycles; busy exactly 32 cycles.
4. winrnd=1, right=1, tie=1 -> tie wins: period 16 (toggle every 8 cycles) for all 32 cycles; exactly 4 toggles total.
5. Right win at k, then left-win pulse at k+10:
   - Default build: the right-win jingle completes unchanged and busy falls at k+33.
   - With WIN_TONE_RETRIGGER_EN: NOTE1 restarts at k+11 with the falling pattern, and busy falls at k+43.
6. rst=1 at k+20 during NOTE2 -> at k+21 speaker=0, en=0, busy=0; a new winrnd at k+25 plays a full 32-cycle jingle.
